// File: rtl/ras_recovery_unit.sv
// ras_recovery_unit
//
// EX-stage resolver for the IF-stage return address stack. Each instruction
// carries the RAS tos/valid_count snapshot taken when it was fetched; when the
// instruction resolves in EX this block decides whether the RAS must be rolled
// back. If so, it produces a registered one-cycle restore pulse, together with
// the pointer/count to restore and whether the RAS should pop once afterwards.
// After each restore, EX input is ignored for SUPPRESS_CYCLES unstalled cycles
// so that wrong-path instructions cannot trigger a second restore.
//
// Optional feature macro: RAS_RECOVERY_STATS_EN
//   defined     -> 32-bit saturating counters of resolved returns/coroutines
//                  and of RAS target mismatches drive the o_stat_* ports
//   not defined -> no counters are built; both o_stat_* ports are tied to 0
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_stall                       EX input not sampled, suppress count frozen
//   i_flush                       trap/mret flush, kills restore and window
//   i_ex_valid                    instruction resolving in EX
//   i_ex_is_call/return/coroutine control-flow class of the instruction
//   i_ex_ras_predicted            IF redirected using the RAS target
//   i_ex_predicted_target         target IF redirected to
//   i_ex_actual_target            resolved target
//   i_ex_ctrl_mispredict          branch/BTB misprediction of this instruction
//   i_ex_checkpoint_tos/_valid_count  RAS snapshot taken in IF
//   o_misprediction               one-cycle restore pulse to the RAS
//   o_restore_tos/_valid_count    restore values (held between pulses)
//   o_pop_after_restore           RAS pops once after restoring
//   o_stat_returns                resolved returns/coroutines
//   o_stat_ras_mispredicts        RAS target mismatches

module ras_recovery_unit #(
  parameter int RAS_DEPTH       = 8,
  parameter int RAS_PTR_BITS    = $clog2(RAS_DEPTH),
  parameter int SUPPRESS_CYCLES = 2,
  parameter int XLEN            = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic                    i_ex_valid,
  input  logic                    i_ex_is_call,
  input  logic                    i_ex_is_return,
  input  logic                    i_ex_is_coroutine,
  input  logic                    i_ex_ras_predicted,
  input  logic [XLEN-1:0]         i_ex_predicted_target,
  input  logic [XLEN-1:0]         i_ex_actual_target,
  input  logic                    i_ex_ctrl_mispredict,
  input  logic [RAS_PTR_BITS-1:0] i_ex_checkpoint_tos,
  input  logic [RAS_PTR_BITS:0]   i_ex_checkpoint_valid_count,
  output logic                    o_misprediction,
  output logic [RAS_PTR_BITS-1:0] o_restore_tos,
  output logic [RAS_PTR_BITS:0]   o_restore_valid_count,
  output logic                    o_pop_after_restore,
  output logic [31:0]             o_stat_returns,
  output logic [31:0]             o_stat_ras_mispredicts
);

  localparam logic [3:0]            SUPPRESS_LOAD = 4'(SUPPRESS_CYCLES);
  localparam logic [RAS_PTR_BITS:0] COUNT_MAX     = (RAS_PTR_BITS + 1)'(RAS_DEPTH);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_SUPPRESS = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              suppress_cnt_q, suppress_cnt_d;
  logic                    misprediction_q, misprediction_d;
  logic [RAS_PTR_BITS-1:0] restore_tos_q, restore_tos_d;
  logic [RAS_PTR_BITS:0]   restore_count_q, restore_count_d;
  logic                    pop_after_restore_q, pop_after_restore_d;

  logic ex_fire;
  logic is_ret_or_coro;
  logic ras_mismatch;
  logic restore_fire;

  // Decide whether the instruction in EX needs a RAS rollback, and compute
  // what the RAS should be rolled back to. Returns and coroutines are checked
  // first (RAS target mismatch, then plain control mispredict); anything else
  // only restores on a control mispredict. A ras-predicted return whose target
  // matched needs no restore even if ctrl_mispredict is also set.
  always_comb begin
    ex_fire        = i_ex_valid && !i_stall && !i_flush && (suppress_cnt_q == 4'd0);
    is_ret_or_coro = i_ex_is_return || i_ex_is_coroutine;
    ras_mismatch   = is_ret_or_coro && i_ex_ras_predicted &&
                     (i_ex_predicted_target != i_ex_actual_target);
    restore_fire   = ex_fire &&
                     (ras_mismatch ||
                      (is_ret_or_coro && !i_ex_ras_predicted && i_ex_ctrl_mispredict) ||
                      (!is_ret_or_coro && i_ex_ctrl_mispredict));

    misprediction_d     = restore_fire;
    restore_tos_d       = restore_tos_q;
    restore_count_d     = restore_count_q;
    pop_after_restore_d = pop_after_restore_q;

    // A call already pushed its link entry in IF, so the restored state has to
    // include that push: pointer advances (wrapping), count saturates at depth.
    if (restore_fire) begin
      if (!is_ret_or_coro && i_ex_is_call) begin
        restore_tos_d       = i_ex_checkpoint_tos + 1'b1;
        restore_count_d     = (i_ex_checkpoint_valid_count >= COUNT_MAX) ?
                              COUNT_MAX : i_ex_checkpoint_valid_count + 1'b1;
        pop_after_restore_d = 1'b0;
      end else begin
        restore_tos_d       = i_ex_checkpoint_tos;
        restore_count_d     = i_ex_checkpoint_valid_count;
        pop_after_restore_d = i_ex_is_return && !i_ex_is_coroutine;
      end
    end
  end

  // Suppress window: a restore opens a window of SUPPRESS_CYCLES unstalled
  // cycles during which EX is ignored. Stalls freeze the count; a flush closes
  // the window immediately.
  always_comb begin
    state_d        = state_q;
    suppress_cnt_d = suppress_cnt_q;
    if (i_flush) begin
      state_d        = ST_IDLE;
      suppress_cnt_d = 4'd0;
    end else if (restore_fire) begin
      state_d        = (SUPPRESS_LOAD == 4'd0) ? ST_IDLE : ST_SUPPRESS;
      suppress_cnt_d = SUPPRESS_LOAD;
    end else if (state_q == ST_SUPPRESS && !i_stall && suppress_cnt_q != 4'd0) begin
      suppress_cnt_d = suppress_cnt_q - 4'd1;
      if (suppress_cnt_q == 4'd1) begin
        state_d = ST_IDLE;
      end
    end
  end

  // All state and registered outputs; reset returns everything to zero on the
  // next edge, including an in-flight pulse or an open window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q             <= ST_IDLE;
      suppress_cnt_q      <= 4'd0;
      misprediction_q     <= 1'b0;
      restore_tos_q       <= '0;
      restore_count_q     <= '0;
      pop_after_restore_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      suppress_cnt_q      <= suppress_cnt_d;
      misprediction_q     <= misprediction_d;
      restore_tos_q       <= restore_tos_d;
      restore_count_q     <= restore_count_d;
      pop_after_restore_q <= pop_after_restore_d;
    end
  end

  assign o_misprediction       = misprediction_q;
  assign o_restore_tos         = restore_tos_q;
  assign o_restore_valid_count = restore_count_q;
  assign o_pop_after_restore   = pop_after_restore_q;

`ifdef RAS_RECOVERY_STATS_EN
  logic [31:0] stat_returns_q, stat_returns_d;
  logic [31:0] stat_ras_mispredicts_q, stat_ras_mispredicts_d;

  // Saturating event counters; only reset clears them.
  always_comb begin
    stat_returns_d         = stat_returns_q;
    stat_ras_mispredicts_d = stat_ras_mispredicts_q;
    if (ex_fire && is_ret_or_coro && stat_returns_q != 32'hFFFF_FFFF) begin
      stat_returns_d = stat_returns_q + 32'd1;
    end
    if (ex_fire && ras_mismatch && stat_ras_mispredicts_q != 32'hFFFF_FFFF) begin
      stat_ras_mispredicts_d = stat_ras_mispredicts_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_returns_q         <= 32'd0;
      stat_ras_mispredicts_q <= 32'd0;
    end else begin
      stat_returns_q         <= stat_returns_d;
      stat_ras_mispredicts_q <= stat_ras_mispredicts_d;
    end
  end

  assign o_stat_returns         = stat_returns_q;
  assign o_stat_ras_mispredicts = stat_ras_mispredicts_q;
`else
  assign o_stat_returns         = 32'd0;
  assign o_stat_ras_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_ras_recovery_unit.sv
// Testbench for ras_recovery_unit: directed scenarios followed by random
// traffic, every cycle checked against a behavioural reference model.

module tb_ras_recovery_unit;

  localparam int DEPTH = 8;
  localparam int SUPP  = 2;

  // Instruction kinds used by the model and stimulus.
  localparam int K_OTHER = 0;
  localparam int K_CALL  = 1;
  localparam int K_RET   = 2;
  localparam int K_CORO  = 3;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_ex_valid;
  logic        i_ex_is_call, i_ex_is_return, i_ex_is_coroutine;
  logic        i_ex_ras_predicted, i_ex_ctrl_mispredict;
  logic [31:0] i_ex_predicted_target, i_ex_actual_target;
  logic [2:0]  i_ex_checkpoint_tos;
  logic [3:0]  i_ex_checkpoint_valid_count;
  logic        o_misprediction, o_pop_after_restore;
  logic [2:0]  o_restore_tos;
  logic [3:0]  o_restore_valid_count;
  logic [31:0] o_stat_returns, o_stat_ras_mispredicts;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the outputs should show, and how many more
  // unstalled cycles EX input must be ignored for.
  bit          m_mis, m_pop;
  int          m_tos, m_cnt, m_window;
  int unsigned m_returns, m_ras_mis;

  ras_recovery_unit #(
    .RAS_DEPTH(DEPTH), .SUPPRESS_CYCLES(SUPP), .XLEN(32)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_ex_valid(i_ex_valid), .i_ex_is_call(i_ex_is_call),
    .i_ex_is_return(i_ex_is_return), .i_ex_is_coroutine(i_ex_is_coroutine),
    .i_ex_ras_predicted(i_ex_ras_predicted),
    .i_ex_predicted_target(i_ex_predicted_target),
    .i_ex_actual_target(i_ex_actual_target),
    .i_ex_ctrl_mispredict(i_ex_ctrl_mispredict),
    .i_ex_checkpoint_tos(i_ex_checkpoint_tos),
    .i_ex_checkpoint_valid_count(i_ex_checkpoint_valid_count),
    .o_misprediction(o_misprediction), .o_restore_tos(o_restore_tos),
    .o_restore_valid_count(o_restore_valid_count),
    .o_pop_after_restore(o_pop_after_restore),
    .o_stat_returns(o_stat_returns),
    .o_stat_ras_mispredicts(o_stat_ras_mispredicts)
  );

  always #5 i_clk = ~i_clk;

  // One comparison: count it, and report and count a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every output with the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".mis"}, 32'(o_misprediction), 32'(m_mis));
    checkOutput({tag, ".tos"}, 32'(o_restore_tos), 32'(m_tos));
    checkOutput({tag, ".cnt"}, 32'(o_restore_valid_count), 32'(m_cnt));
    checkOutput({tag, ".pop"}, 32'(o_pop_after_restore), 32'(m_pop));
`ifdef RAS_RECOVERY_STATS_EN
    checkOutput({tag, ".st_ret"}, o_stat_returns, 32'(m_returns));
    checkOutput({tag, ".st_mis"}, o_stat_ras_mispredicts, 32'(m_ras_mis));
`else
    checkOutput({tag, ".st_ret"}, o_stat_returns, 32'd0);
    checkOutput({tag, ".st_mis"}, o_stat_ras_mispredicts, 32'd0);
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the rules of the block,
  // then compare outputs a little after the edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit stall,
                               input bit flush, input bit valid, input int kind,
                               input bit ras_pred, input int unsigned pred,
                               input int unsigned act, input bit ctrl,
                               input int tos, input int cnt);
    bit accept, is_rc, mismatch, restore;
    i_rst                       = rst;
    i_stall                     = stall;
    i_flush                     = flush;
    i_ex_valid                  = valid;
    i_ex_is_call                = (kind == K_CALL);
    i_ex_is_return              = (kind == K_RET);
    i_ex_is_coroutine           = (kind == K_CORO);
    i_ex_ras_predicted          = ras_pred;
    i_ex_predicted_target       = pred;
    i_ex_actual_target          = act;
    i_ex_ctrl_mispredict        = ctrl;
    i_ex_checkpoint_tos         = 3'(tos);
    i_ex_checkpoint_valid_count = 4'(cnt);

    accept   = valid && !stall && !flush && (m_window == 0);
    is_rc    = (kind == K_RET) || (kind == K_CORO);
    mismatch = is_rc && ras_pred && (pred != act);
    restore  = accept && (mismatch || (is_rc && !ras_pred && ctrl) || (!is_rc && ctrl));

    @(posedge i_clk);
    #1;
    if (rst) begin
      m_mis = 0; m_tos = 0; m_cnt = 0; m_pop = 0; m_window = 0;
      m_returns = 0; m_ras_mis = 0;
    end else begin
      m_mis = restore;
      if (restore) begin
        if (kind == K_CALL) begin
          m_tos = (tos + 1) % DEPTH;
          m_cnt = (cnt + 1 > DEPTH) ? DEPTH : cnt + 1;
          m_pop = 0;
        end else begin
          m_tos = tos;
          m_cnt = cnt;
          m_pop = (kind == K_RET);
        end
      end
      if (accept && is_rc) m_returns++;
      if (accept && mismatch) m_ras_mis++;
      if (flush) m_window = 0;
      else if (restore) m_window = SUPP;
      else if (m_window > 0 && !stall) m_window--;
    end
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, K_OTHER, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic branchMiss(input string tag, input bit stall, input bit flush);
    applyStimulus(tag, 0, stall, flush, 1, K_OTHER, 0, 32'h100, 32'h200, 1, 5, 6);
  endtask

  initial begin
    int kind, tos, cnt;
    bit rst, stall, flush, valid, rp, ctrl;
    int unsigned pred, act;

    m_mis = 0; m_pop = 0; m_tos = 0; m_cnt = 0; m_window = 0;
    m_returns = 0; m_ras_mis = 0;

    applyStimulus("reset0", 1, 0, 0, 0, K_OTHER, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset1", 1, 0, 0, 1, K_OTHER, 0, 0, 0, 1, 3, 3);
    idle("idle");

    // Correctly predicted return: no restore.
    applyStimulus("ret_ok", 0, 0, 0, 1, K_RET, 1, 32'h80, 32'h80, 0, 1, 2);

    // Return target mismatch: restore to checkpoint and pop, then window.
    applyStimulus("ret_bad", 0, 0, 0, 1, K_RET, 1, 32'h80, 32'h84, 0, 3, 4);
    branchMiss("win1", 0, 0);
    branchMiss("win2", 0, 0);
    branchMiss("after_win", 0, 0);
    idle("i1"); idle("i2");

    // Call mispredict: pointer wraps, count saturates.
    applyStimulus("call", 0, 0, 0, 1, K_CALL, 0, 0, 0, 1, 7, 8);
    idle("i3"); idle("i4");

    // Coroutine mismatch: checkpoint, no pop.
    applyStimulus("coro", 0, 0, 0, 1, K_CORO, 1, 32'h40, 32'h44, 0, 2, 1);
    idle("i5"); idle("i6");

    // Flush wins over a same-cycle mispredict.
    branchMiss("flush_kill", 0, 1);
    idle("i7");

    // Window extended by stalls.
    branchMiss("bm_fire", 0, 0);
    branchMiss("stall1", 1, 0);
    branchMiss("stall2", 1, 0);
    branchMiss("unst1", 0, 0);
    branchMiss("unst2", 0, 0);
    branchMiss("bm_again", 0, 0);

    // Reset inside the window clears state; next mispredict accepted at once.
    applyStimulus("rst_win", 1, 0, 0, 1, K_OTHER, 0, 0, 0, 1, 4, 4);
    branchMiss("post_rst", 0, 0);
    idle("i8"); idle("i9");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 8);
      valid = ($urandom_range(0, 99) < 75);
      kind  = $urandom_range(0, 3);
      rp    = $urandom_range(0, 1);
      ctrl  = ($urandom_range(0, 99) < 40);
      pred  = 32'h1000 + 4 * $urandom_range(0, 2);
      act   = 32'h1000 + 4 * $urandom_range(0, 2);
      tos   = $urandom_range(0, DEPTH - 1);
      cnt   = $urandom_range(0, DEPTH);
      applyStimulus("rand", rst, stall, flush, valid, kind, rp, pred, act, ctrl, tos, cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
